// File: rtl/hash_pkg.sv
// -----------------------------------------------------------------------------
// hash_pkg
// Shared definitions for the DES-S-box hash core front end.
//   LEN_W          default width of a message length, in bytes
//   BYTE_W         width of one message byte presented to the core
//   WORD_W         width of one host word (four byte lanes)
//   feeder_state_t states of the message feeder FSM
// -----------------------------------------------------------------------------
package hash_pkg;

    localparam int LEN_W  = 64;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // FD_IDLE   : waiting for a start, start_ready high
    // FD_STREAM : accepting host words and emitting bytes to the core
    // FD_DRAIN  : last byte sent, giving the core time to finalise
    typedef enum logic [1:0] {
        FD_IDLE   = 2'd0,
        FD_STREAM = 2'd1,
        FD_DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/hash_word_fifo.sv
// -----------------------------------------------------------------------------
// hash_word_fifo
// Small synchronous FIFO holding host words until the feeder has serialised
// them into bytes. The head word is visible combinationally on dout so the
// feeder can pick a byte lane out of it in the same cycle it decides to emit.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (empties the FIFO)
//   push         write din at the tail (ignored while full)
//   pop          drop the head word (ignored while empty)
//   din          word to write
//   dout         current head word
//   full, empty  occupancy flags derived from the read/write pointers
// -----------------------------------------------------------------------------
module hash_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    // The extra pointer MSB tells a completely full FIFO apart from an empty
    // one when both addresses coincide.
    assign empty = (r_wrPtr == r_rdPtr);
    assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

    // Guard the handshakes here as well so a misbehaving caller can never
    // corrupt the pointers.
    assign w_doPush = push & ~full;
    assign w_doPop  = pop & ~empty;

    assign dout = r_mem[r_rdPtr[AW-1:0]];

    // Pointer registers; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

    // Storage has no reset: contents are meaningless until the write pointer
    // moves past them.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/hash_msg_feeder.sv
// -----------------------------------------------------------------------------
// hash_msg_feeder
// Upstream stage of the DES-S-box hash core. Takes a message length and a
// stream of 32-bit host words, buffers the words and hands the core one byte
// per cycle. The core sees exactly C_in bytes, C_in is stable from the first
// byte, and a new message cannot start until the core's finalise window has
// passed.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         begin a message, msg_len sampled in the same cycle
//   msg_len       message length in bytes
//   start_ready   high while idle, i.e. when a start will be accepted
//   len_err       one-cycle pulse after a start with msg_len == 0
//   word_valid    host word valid
//   word_data     host word, byte0 in [7:0] ... byte3 in [31:24]
//   word_ready    host word accepted when word_valid & word_ready at posedge
//   M_valid       registered byte valid to the hash core
//   M             registered message byte
//   C_in          latched message length for the whole message
//   busy          high while streaming or draining
// -----------------------------------------------------------------------------
module hash_msg_feeder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int LEN_W        = hash_pkg::LEN_W,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             start_ready,
    output logic             len_err,
    input  logic             word_valid,
    input  logic [31:0]      word_data,
    output logic             word_ready,
    output logic             M_valid,
    output logic [7:0]       M,
    output logic [LEN_W-1:0] C_in,
    output logic             busy
);

    import hash_pkg::*;

    // One extra bit so the counter can hold DRAIN_CYCLES itself, and never
    // collapses to zero width when DRAIN_CYCLES is 0.
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1) + 1;

    feeder_state_t      r_state;
    feeder_state_t      w_nextState;

    logic [LEN_W-1:0]   r_bytesRem;
    logic [LEN_W:0]     r_wordsRem;
    logic [LEN_W:0]     w_wordsNeeded;
    logic [1:0]         r_lane;
    logic [DRAIN_W-1:0] r_drainCnt;
    logic [LEN_W-1:0]   r_cIn;
    logic               r_mValid;
    logic [BYTE_W-1:0]  r_m;
    logic               r_lenErr;

    logic               w_startOk;
    logic               w_startBad;
    logic               w_wordReady;
    logic               w_push;
    logic               w_pop;
    logic               w_emit;
    logic               w_lastByte;
    logic               w_drainDone;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic [WORD_W-1:0]  w_head;

    // Word buffer between the host and the byte serialiser.
    hash_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (word_data),
        .dout  (w_head),
        .full  (w_fifoFull),
        .empty (w_fifoEmpty)
    );

    // Start handling: only idle starts count, and a zero length is refused
    // rather than sending an empty message to the core.
    assign w_startOk  = (r_state == FD_IDLE) & start & (msg_len != '0);
    assign w_startBad = (r_state == FD_IDLE) & start & (msg_len == '0);

    // Rounded-up word count, one bit wider so an all-ones length cannot wrap.
    assign w_wordsNeeded = ({1'b0, msg_len} + (LEN_W+1)'(3)) >> 2;

    // Host side: never accept more words than the message needs, and a full
    // FIFO blocks even when a pop happens in the same cycle.
    assign w_wordReady = (r_state == FD_STREAM) & ~w_fifoFull & (r_wordsRem != '0);
    assign w_push      = word_valid & w_wordReady;

    // Core side: one byte per cycle whenever a buffered word is available.
    // The head word is released after its last lane, or early on the final
    // byte so trailing pad bytes of the last word are simply dropped.
    assign w_emit      = (r_state == FD_STREAM) & ~w_fifoEmpty & (r_bytesRem != '0);
    assign w_lastByte  = (r_bytesRem == LEN_W'(1));
    assign w_pop       = w_emit & ((r_lane == 2'd3) | w_lastByte);

    // The drain window covers the cycle the last byte is on M plus
    // DRAIN_CYCLES idle cycles for the core to finalise.
    assign w_drainDone = (r_drainCnt == DRAIN_W'(DRAIN_CYCLES));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: idle until a valid start, stream until the last byte
    // leaves, then drain before accepting another message.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FD_IDLE: begin
                if (w_startOk) begin
                    w_nextState = FD_STREAM;
                end
            end
            FD_STREAM: begin
                if (w_emit && w_lastByte) begin
                    w_nextState = FD_DRAIN;
                end
            end
            FD_DRAIN: begin
                if (w_drainDone) begin
                    w_nextState = FD_IDLE;
                end
            end
            default: begin
                w_nextState = FD_IDLE;
            end
        endcase
    end

    // Message counters and the latched length. A start can only be accepted
    // in idle while pushes and emits only happen while streaming, so the two
    // branches never compete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cIn      <= '0;
            r_bytesRem <= '0;
            r_wordsRem <= '0;
            r_lane     <= 2'd0;
        end else if (w_startOk) begin
            r_cIn      <= msg_len;
            r_bytesRem <= msg_len;
            r_wordsRem <= w_wordsNeeded;
            r_lane     <= 2'd0;
        end else begin
            if (w_push) begin
                r_wordsRem <= r_wordsRem - (LEN_W+1)'(1);
            end
            if (w_emit) begin
                r_bytesRem <= r_bytesRem - LEN_W'(1);
                r_lane     <= r_lane + 2'd1;
            end
        end
    end

    // Drain timer runs only while draining and is cleared everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drainCnt <= '0;
        end else if (r_state == FD_DRAIN) begin
            r_drainCnt <= r_drainCnt + DRAIN_W'(1);
        end else begin
            r_drainCnt <= '0;
        end
    end

    // Registered byte interface and error pulse. M keeps its last value
    // between bytes; only M_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mValid <= 1'b0;
            r_m      <= '0;
            r_lenErr <= 1'b0;
        end else begin
            r_mValid <= w_emit;
            r_lenErr <= w_startBad;
            if (w_emit) begin
                r_m <= w_head[{r_lane, 3'b000} +: BYTE_W];
            end
        end
    end

    assign start_ready = (r_state == FD_IDLE);
    assign busy        = (r_state != FD_IDLE);
    assign word_ready  = w_wordReady;
    assign len_err     = r_lenErr;
    assign M_valid     = r_mValid;
    assign M           = r_m;
    assign C_in        = r_cIn;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// -----------------------------------------------------------------------------
// tb_hash_msg_feeder
// Self-checking bench for hash_msg_feeder. A behavioural model tracks each
// message as a byte queue, word/byte counts and the cycle the last byte left,
// and a negedge process compares every DUT output against it each cycle.
// Directed scenarios pin the model with hand-computed values, followed by
// randomized messages.
// -----------------------------------------------------------------------------
module tb_hash_msg_feeder;

   localparam int FIFO_DEPTH   = 4;
   localparam int LEN_W        = 64;
   localparam int DRAIN_CYCLES = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] msg_len = '0;
   logic             start_ready;
   logic             len_err;
   logic             word_valid = 1'b0;
   logic [31:0]      word_data = '0;
   logic             word_ready;
   logic             M_valid;
   logic [7:0]       M;
   logic [LEN_W-1:0] C_in;
   logic             busy;

   int checks = 0;
   int errors = 0;

   hash_msg_feeder #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .LEN_W        (LEN_W),
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .msg_len     (msg_len),
      .start_ready (start_ready),
      .len_err     (len_err),
      .word_valid  (word_valid),
      .word_data   (word_data),
      .word_ready  (word_ready),
      .M_valid     (M_valid),
      .M           (M),
      .C_in        (C_in),
      .busy        (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison point: every check goes through here so the counters
   // in the summary line are the ones that the checks step.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: one message at a time, described by its length,
   // how many words and bytes have crossed each interface, and the bytes the
   // core is still owed.
   int               cyc = 0;
   bit               mActive = 1'b0;
   logic [63:0]      mLen = '0;
   logic [63:0]      mCin = '0;
   longint unsigned  mEmit = 0;
   longint unsigned  mPushed = 0;
   longint unsigned  mAppended = 0;
   longint unsigned  mNw = 0;
   logic [7:0]       expQ[$];
   int               lastByteEdge = -1000;
   bit               pendEmit = 1'b0;
   bit               pendLenErr = 1'b0;
   logic [7:0]       pendByte = '0;

   // Observation record used by the directed scenarios.
   logic [7:0]       obsBytes[$];
   int               lenErrCount = 0;
   int               validCount = 0;
   int               firstValid = 0;
   int               lastValid = 0;

   // Per-cycle compare against the model, then advance the model by what the
   // coming rising edge will do with the inputs now on the pins.
   always @(negedge clk) begin : compare
      bit              expStartReady;
      bit              expWordReady;
      bit              doPush;
      bit              doEmit;
      bit              startAcc;
      longint unsigned occ;
      cyc++;
      if (!rst_n) begin
         mActive      = 1'b0;
         mLen         = '0;
         mCin         = '0;
         mEmit        = 0;
         mPushed      = 0;
         mAppended    = 0;
         mNw          = 0;
         expQ.delete();
         lastByteEdge = -1000;
         pendEmit     = 1'b0;
         pendLenErr   = 1'b0;
      end else begin
         if (M_valid) begin
            obsBytes.push_back(M);
            validCount++;
            if (validCount == 1) firstValid = cyc;
            lastValid = cyc;
         end
         if (len_err) lenErrCount++;

         // Words leave the buffer once all four lanes are used, or at the end.
         occ           = mPushed - mEmit / 4;
         expStartReady = !mActive && (cyc >= lastByteEdge + DRAIN_CYCLES + 1);
         expWordReady  = mActive && (mPushed < mNw) && (occ < FIFO_DEPTH);

         checkOutput("M_valid", 64'(M_valid), 64'(pendEmit));
         if (pendEmit) checkOutput("M", 64'(M), 64'(pendByte));
         checkOutput("C_in", C_in, mCin);
         checkOutput("start_ready", 64'(start_ready), 64'(expStartReady));
         checkOutput("busy", 64'(busy), 64'(!expStartReady));
         checkOutput("len_err", 64'(len_err), 64'(pendLenErr));
         checkOutput("word_ready", 64'(word_ready), 64'(expWordReady));

         doPush   = word_valid && expWordReady;
         doEmit   = mActive && (occ > 0);
         startAcc = start && expStartReady;

         pendEmit   = doEmit;
         pendLenErr = startAcc && (msg_len == '0);
         if (doEmit) begin
            pendByte = expQ.pop_front();
            mEmit++;
            if (mEmit == mLen) begin
               mActive      = 1'b0;
               lastByteEdge = cyc + 1;
            end
         end
         if (doPush) begin
            for (int b = 0; b < 4; b++) begin
               if (mAppended < mLen) begin
                  expQ.push_back(word_data[8*b +: 8]);
                  mAppended++;
               end
            end
            mPushed++;
         end
         if (startAcc && (msg_len != '0)) begin
            mActive   = 1'b1;
            mLen      = msg_len;
            mCin      = msg_len;
            mEmit     = 0;
            mPushed   = 0;
            mAppended = 0;
            mNw       = msg_len / 4 + 64'((msg_len % 4) != 0);
            expQ.delete();
         end
      end
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit s, input logic [63:0] len, input bit wv, input logic [31:0] wd);
      start      = s;
      msg_len    = len;
      word_valid = wv;
      word_data  = wd;
   endtask

   task automatic startMsg(input logic [63:0] len);
      for (int t = 0; t < 100; t++) begin
         if (start_ready) break;
         step();
      end
      checkOutput("start_ready before start", 64'(start_ready), 64'd1);
      applyStimulus(1'b1, len, 1'b0, 32'h0);
      step();
      start = 1'b0;
   endtask

   task automatic driveWord(input logic [31:0] w);
      bit acc;
      acc        = 1'b0;
      word_valid = 1'b1;
      word_data  = w;
      for (int t = 0; t < 200; t++) begin
         acc = word_ready;
         step();
         if (acc) break;
      end
      word_valid = 1'b0;
      checkOutput("word accepted", 64'(acc), 64'd1);
   endtask

   task automatic waitIdle();
      for (int t = 0; t < 500; t++) begin
         if (start_ready) break;
         step();
      end
      checkOutput("return to idle", 64'(start_ready), 64'd1);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int       k;
      int       toggles;
      int       nWords;
      bit       prevRdy;
      bit       acc;
      bit       found;
      logic [7:0] exp2[6];
      logic [63:0] rlen;

      // Reset values.
      #1;
      checkOutput("reset start_ready", 64'(start_ready), 64'd1);
      checkOutput("reset M_valid", 64'(M_valid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset word_ready", 64'(word_ready), 64'd0);
      checkOutput("reset C_in", C_in, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Scenario 1: single-byte message and the drain window length.
      $display("[TB] scenario 1: len=1");
      obsBytes.delete();
      startMsg(64'd1);
      driveWord(32'h0000_00A5);
      for (int t = 0; t < 20; t++) begin
         if (M_valid) break;
         step();
      end
      checkOutput("t1 M_valid", 64'(M_valid), 64'd1);
      checkOutput("t1 M", 64'(M), 64'hA5);
      checkOutput("t1 C_in", C_in, 64'd1);
      k = 0;
      while (!start_ready && k < 20) begin
         step();
         k++;
      end
      checkOutput("t1 drain cycles", 64'(k), 64'(DRAIN_CYCLES + 1));
      checkOutput("t1 byte count", 64'(obsBytes.size()), 64'd1);

      // Scenario 2: six bytes from two words, pad bytes dropped.
      $display("[TB] scenario 2: len=6");
      obsBytes.delete();
      exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      startMsg(64'd6);
      driveWord(32'h4433_2211);
      driveWord(32'hDDCC_6655);
      checkOutput("t2 word_ready after count", 64'(word_ready), 64'd0);
      waitIdle();
      checkOutput("t2 byte count", 64'(obsBytes.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < obsBytes.size()) checkOutput("t2 byte", 64'(obsBytes[i]), 64'(exp2[i]));
      end

      // Scenario 3: zero-length start is refused.
      $display("[TB] scenario 3: len=0");
      obsBytes.delete();
      lenErrCount = 0;
      startMsg(64'd0);
      for (int t = 0; t < 5; t++) begin
         checkOutput("t3 start_ready", 64'(start_ready), 64'd1);
         step();
      end
      checkOutput("t3 len_err pulses", 64'(lenErrCount), 64'd1);
      checkOutput("t3 no bytes", 64'(obsBytes.size()), 64'd0);

      // Scenario 4: host always valid, 32 incrementing bytes.
      $display("[TB] scenario 4: len=32 back-to-back");
      obsBytes.delete();
      validCount = 0;
      toggles    = 0;
      nWords     = 0;
      startMsg(64'd32);
      prevRdy = word_ready;
      for (int t = 0; t < 300; t++) begin
         if (nWords >= 8) break;
         word_valid = 1'b1;
         word_data  = {8'(4*nWords+3), 8'(4*nWords+2), 8'(4*nWords+1), 8'(4*nWords)};
         acc = word_ready;
         if (prevRdy && !word_ready) toggles++;
         prevRdy = word_ready;
         step();
         if (acc) nWords++;
      end
      word_valid = 1'b0;
      waitIdle();
      checkOutput("t4 words", 64'(nWords), 64'd8);
      checkOutput("t4 byte count", 64'(obsBytes.size()), 64'd32);
      for (int i = 0; i < 32; i++) begin
         if (i < obsBytes.size()) checkOutput("t4 byte", 64'(obsBytes[i]), 64'(i));
      end
      checkOutput("t4 contiguous", 64'(lastValid - firstValid + 1), 64'd32);
      checkOutput("t4 word_ready toggled", 64'(toggles != 0), 64'd1);

      // Scenario 5: start during streaming is ignored.
      $display("[TB] scenario 5: start mid-stream");
      obsBytes.delete();
      lenErrCount = 0;
      startMsg(64'd12);
      driveWord(32'h0403_0201);
      applyStimulus(1'b1, 64'd9, 1'b0, 32'h0);
      step();
      start = 1'b0;
      checkOutput("t5 C_in held", C_in, 64'd12);
      checkOutput("t5 still busy", 64'(busy), 64'd1);
      driveWord(32'h0807_0605);
      driveWord(32'h0C0B_0A09);
      waitIdle();
      checkOutput("t5 byte count", 64'(obsBytes.size()), 64'd12);
      checkOutput("t5 C_in final", C_in, 64'd12);
      checkOutput("t5 no len_err", 64'(lenErrCount), 64'd0);

      // Scenario 6: asynchronous reset in the middle of a message.
      $display("[TB] scenario 6: reset mid-message");
      obsBytes.delete();
      startMsg(64'd8);
      driveWord(32'h0403_0201);
      driveWord(32'h0807_0605);
      found = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (M_valid && M == 8'h03) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checkOutput("t6 reached byte 3", 64'(found), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6 start_ready", 64'(start_ready), 64'd1);
      checkOutput("t6 busy", 64'(busy), 64'd0);
      checkOutput("t6 M_valid", 64'(M_valid), 64'd0);
      checkOutput("t6 M", 64'(M), 64'd0);
      checkOutput("t6 C_in", C_in, 64'd0);
      checkOutput("t6 word_ready", 64'(word_ready), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      obsBytes.delete();
      step();
      startMsg(64'd2);
      driveWord(32'h0000_BBAA);
      waitIdle();
      checkOutput("t6 byte count", 64'(obsBytes.size()), 64'd2);
      if (obsBytes.size() == 2) begin
         checkOutput("t6 byte0", 64'(obsBytes[0]), 64'hAA);
         checkOutput("t6 byte1", 64'(obsBytes[1]), 64'hBB);
      end

      // Randomized messages with host stalls and stray starts while busy.
      $display("[TB] randomized messages");
      for (int m = 0; m < 15; m++) begin
         if (m % 5 == 4) begin
            startMsg(64'd0);
            step();
         end
         rlen = 64'($urandom_range(1, 40));
         startMsg(rlen);
         for (int t = 0; t < 3000; t++) begin
            word_valid = ($urandom_range(0, 3) != 0);
            word_data  = $urandom;
            if (busy && $urandom_range(0, 15) == 0) begin
               start   = 1'b1;
               msg_len = 64'($urandom_range(0, 50));
            end else begin
               start = 1'b0;
            end
            step();
            if (start_ready) break;
         end
         start      = 1'b0;
         word_valid = 1'b0;
         checkOutput("random message done", 64'(start_ready), 64'd1);
      end

      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
